// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers column, row and display enable from an external
// h/v sync pair, measures line/frame timing and declares lock after good frames.
// Ports: pixel_clk, reset (sync, active high), h_sync_in, v_sync_in (inputs);
//        disp_ena, column, row, locked, h_meas, v_meas, err_count (outputs).
module vga_sync_decoder #(
   parameter int   h_pixels    = 640,
   parameter int   h_fp        = 16,
   parameter int   h_pulse     = 96,
   parameter int   h_bp        = 48,
   parameter logic h_pol       = 1'b0,
   parameter int   v_pixels    = 480,
   parameter int   v_fp        = 10,
   parameter int   v_pulse     = 2,
   parameter int   v_bp        = 33,
   parameter logic v_pol       = 1'b0,
   parameter int   pulse_tol   = 1,
   parameter int   lock_frames = 2
) (
   input  logic                                             pixel_clk,
   input  logic                                             reset,
   input  logic                                             h_sync_in,
   input  logic                                             v_sync_in,
   output logic                                             disp_ena,
   output logic [$clog2(h_pixels)-1:0]                      column,
   output logic [$clog2(v_pixels)-1:0]                      row,
   output logic                                             locked,
   output logic [$clog2(h_pulse+h_bp+h_pixels+h_fp):0]      h_meas,
   output logic [$clog2(v_pulse+v_bp+v_pixels+v_fp):0]      v_meas,
   output logic [7:0]                                       err_count
);

   localparam int h_period = h_pulse + h_bp + h_pixels + h_fp;
   localparam int v_period = v_pulse + v_bp + v_pixels + v_fp;
   localparam int cw       = $clog2(h_pixels);
   localparam int rw       = $clog2(v_pixels);
   localparam int hmw      = $clog2(h_period) + 1;
   localparam int vmw      = $clog2(v_period) + 1;
   localparam int h_pw_min = h_pulse - pulse_tol;
   localparam int h_pw_max = h_pulse + pulse_tol;
   localparam int v_pw_min = v_pulse - pulse_tol;
   localparam int v_pw_max = v_pulse + pulse_tol;

   typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

   state_t         state;
   logic [7:0]     good;
   logic           frame_bad;

   logic           h_prev;
   logic           v_prev;
   logic           h_act;
   logic           v_act;
   logic           h_lead;
   logic           h_trail;
   logic           v_lead;
   logic           v_trail;

   logic [hmw-1:0] h_cnt;
   logic [vmw-1:0] v_cnt;
   logic           h_wrap;
   logic           h_vis;
   logic           v_vis;

   logic [hmw-1:0] h_pcnt;
   logic [hmw-1:0] h_pmeas;
   logic [hmw-1:0] h_wcnt;
   logic [vmw-1:0] v_lcnt;
   logic [vmw-1:0] v_lmeas;
   logic [vmw-1:0] v_wcnt;
   logic           h_seen;
   logic           v_seen;

   logic           h_per_bad;
   logic           h_pw_bad;
   logic           v_per_bad;
   logic           v_pw_bad;
   logic           timeout;
   logic           mis;
   logic           to_search;
   logic           lock_nx;

   // Edge detection against the registered previous sample
   assign h_act   = (h_sync_in == h_pol);
   assign v_act   = (v_sync_in == v_pol);
   assign h_lead  = h_act && (h_prev != h_pol);
   assign h_trail = !h_act && (h_prev == h_pol);
   assign v_lead  = v_act && (v_prev != v_pol);
   assign v_trail = !v_act && (v_prev == v_pol);

   assign h_wrap = !h_lead && (h_cnt == hmw'(h_period - 1));
   assign h_vis  = (h_cnt < hmw'(h_pixels));
   assign v_vis  = (v_cnt < vmw'(v_pixels));

   // Period samples include the edge cycle itself; both saturate
   assign h_pmeas = (h_pcnt == '1) ? h_pcnt : h_pcnt + 1'b1;
   assign v_lmeas = (h_lead && v_lcnt != '1) ? v_lcnt + 1'b1 : v_lcnt;

   assign h_per_bad = h_lead && h_seen && (h_pmeas != hmw'(h_period));
   assign v_per_bad = v_lead && v_seen && (v_lmeas != vmw'(v_period));
   assign h_pw_bad  = h_trail &&
                      ((int'(h_wcnt) < h_pw_min) || (int'(h_wcnt) > h_pw_max));
   assign v_pw_bad  = v_trail &&
                      ((int'(v_wcnt) < v_pw_min) || (int'(v_wcnt) > v_pw_max));
   // Fires once, on the first clock of the 2*h_period-th edgeless cycle
   assign timeout   = !h_lead && (h_pcnt == hmw'(2 * h_period - 1));
   assign mis       = h_per_bad || h_pw_bad || v_per_bad || v_pw_bad || timeout;

   assign to_search = (state == LOCKED) ? mis :
                      (state == VERIFY) &&
                      (timeout || (v_lead && (frame_bad || mis)));

   assign lock_nx   = (state == LOCKED) ? !mis :
                      (state == VERIFY) && v_lead && !frame_bad && !mis &&
                      (good == 8'(lock_frames - 1));

   // Recovered raster position
   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         if (h_lead)
            h_cnt <= hmw'(h_pixels + h_fp + 1);
         else if (h_wrap)
            h_cnt <= '0;
         else
            h_cnt <= h_cnt + 1'b1;

         if (v_lead)
            v_cnt <= vmw'(v_pixels + v_fp);
         else if (h_wrap)
            v_cnt <= (v_cnt == vmw'(v_period - 1)) ? '0 : v_cnt + 1'b1;
      end
   end

   // Timing measurement
   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         h_prev <= ~h_pol;
         v_prev <= ~v_pol;
         h_pcnt <= '0;
         h_wcnt <= '0;
         v_lcnt <= '0;
         v_wcnt <= '0;
         h_meas <= '0;
         v_meas <= '0;
         h_seen <= 1'b0;
         v_seen <= 1'b0;
      end else begin
         h_prev <= h_sync_in;
         v_prev <= v_sync_in;

         if (h_lead)
            h_pcnt <= '0;
         else if (h_pcnt != '1)
            h_pcnt <= h_pcnt + 1'b1;

         if (h_lead)
            h_wcnt <= hmw'(1);
         else if (h_act && h_wcnt != '1)
            h_wcnt <= h_wcnt + 1'b1;

         if (v_lead)
            v_lcnt <= '0;
         else
            v_lcnt <= v_lmeas;

         if (v_lead)
            v_wcnt <= vmw'(h_lead);
         else if (v_act && h_lead && v_wcnt != '1)
            v_wcnt <= v_wcnt + 1'b1;

         if (h_lead && h_seen)
            h_meas <= h_pmeas;
         if (v_lead && v_seen)
            v_meas <= v_lmeas;

         // The first edge after (re)entering SEARCH only arms measurement
         if (to_search) begin
            h_seen <= 1'b0;
            v_seen <= 1'b0;
         end else begin
            if (h_lead)
               h_seen <= 1'b1;
            if (v_lead)
               v_seen <= 1'b1;
         end
      end
   end

   // Lock FSM
   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         state     <= SEARCH;
         good      <= '0;
         frame_bad <= 1'b0;
         locked    <= 1'b0;
         err_count <= '0;
      end else begin
         unique case (state)
            SEARCH: begin
               if (v_lead) begin
                  state     <= VERIFY;
                  good      <= '0;
                  frame_bad <= 1'b0;
               end
            end
            VERIFY: begin
               if (timeout) begin
                  state <= SEARCH;
               end else if (v_lead) begin
                  frame_bad <= 1'b0;
                  if (frame_bad || mis) begin
                     state <= SEARCH;
                  end else begin
                     good <= good + 1'b1;
                     if (good == 8'(lock_frames - 1))
                        state <= LOCKED;
                  end
               end else if (mis) begin
                  frame_bad <= 1'b1;
               end
            end
            LOCKED: begin
               if (mis) begin
                  state <= SEARCH;
                  if (err_count != 8'hFF)
                     err_count <= err_count + 1'b1;
               end
            end
            default: state <= SEARCH;
         endcase
         locked <= lock_nx;
      end
   end

   // Registered raster outputs
   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         column   <= '0;
         row      <= '0;
         disp_ena <= 1'b0;
      end else begin
         if (h_vis)
            column <= h_cnt[cw-1:0];
         if (v_vis)
            row <= v_cnt[rw-1:0];
         disp_ena <= lock_nx && h_vis && v_vis;
      end
   end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart to the VGA sync generator: takes h_sync/v_sync sampled in the pixel clock domain and recovers column, row and display enable.
- Measures line and frame timing, checks it against the mode parameters, and declares lock after consecutive good frames.
- Used for loopback self-check of the video path and as a front end for capture/overlay logic fed by an external sync source.
- No CDC: inputs are synchronous to pixel_clk.

Parameters:
h_pixels, 640, active pixels per line
h_fp, 16, horizontal front porch (clocks)
h_pulse, 96, horizontal sync width (clocks)
h_bp, 48, horizontal back porch (clocks)
h_pol, 1'b0, h_sync active level
v_pixels, 480, active lines per frame
v_fp, 10, vertical front porch (lines)
v_pulse, 2, vertical sync width (lines)
v_bp, 33, vertical back porch (lines)
v_pol, 1'b0, v_sync active level
pulse_tol, 1, allowed ± deviation of measured sync widths
lock_frames, 2, consecutive good frames required for lock

Ports:
pixel_clk  in  1  pixel clock
reset  in  1  synchronous reset, active high
h_sync_in  in  1  horizontal sync, polarity h_pol
v_sync_in  in  1  vertical sync, polarity v_pol
disp_ena  out  1  recovered display enable, 0 whenever not locked
column  out  $clog2(h_pixels)  recovered pixel column
row  out  $clog2(v_pixels)  recovered pixel row
locked  out  1  timing matches parameters
h_meas  out  $clog2(h_period)+1  last measured line period, clocks
v_meas  out  $clog2(v_period)+1  last measured frame period, lines
err_count  out  8  saturating count of LOCKED->SEARCH transitions

Behaviour:
- Timing constants: h_period = h_pulse+h_bp+h_pixels+h_fp (800); v_period = v_pulse+v_bp+v_pixels+v_fp (525).
- Reset: one cycle with reset=1 clears all state. All outputs 0, FSM=SEARCH, input history registers = inactive level.
- Edge detect: a leading edge is the cycle where the input is active and the registered previous sample was inactive. A trailing edge is the reverse. Detection is on the same cycle as the input change.
- h counter h_cnt:
  - On an h leading edge, h_cnt loads h_pixels+h_fp+1. The edge cycle itself therefore corresponds to position h_pixels+h_fp (656).
  - Otherwise it increments, wrapping from h_period-1 to 0.
- v counter v_cnt:
  - Increments on the h_cnt wrap to 0, wrapping from v_period-1 to 0.
  - On a v leading edge it loads v_pixels+v_fp (490).
  - Load wins over a coincident increment.
- Outputs (registered, one cycle after the counter value):
  - column <= h_cnt while h_cnt<h_pixels, else hold.
  - row <= v_cnt while v_cnt<v_pixels, else hold.
  - disp_ena <= locked_next && h_cnt<h_pixels && v_cnt<v_pixels.
- h period measurement:
  - A free counter is cleared on each h leading edge.
  - At each h leading edge except the first after entering SEARCH: h_meas <= count+1; mismatch if it differs from h_period.
  - The counter saturates at all-ones.
- h pulse width: counted from leading to trailing edge. Mismatch if outside [h_pulse-pulse_tol, h_pulse+pulse_tol].
- v period measurement: lines counted by h leading edges between v leading edges. At each v leading edge except the first after SEARCH: v_meas <= lines; mismatch if ≠ v_period.
- v pulse width: measured in h leading edges seen while v active. Same tolerance rule as h.
- Timeout: no h leading edge for 2*h_period clocks counts as a mismatch. The FSM goes to SEARCH; h_meas and v_meas hold.
- FSM:
  - SEARCH: on a v leading edge go to VERIFY, good=0, frame mismatch flag cleared.
  - VERIFY: any mismatch sets the frame flag. At a v leading edge: if the flag is clear, good++; when good reaches lock_frames, go to LOCKED. If the flag is set, go to SEARCH.
  - LOCKED: locked=1. Any mismatch → SEARCH the same cycle; err_count++ (saturates at 255); locked and disp_ena fall on the next clock.
- Simultaneous h and v leading edges: both are processed. The v period sample includes that line.
- Reset mid-operation overrides everything, including a pending transition to LOCKED.

Test Plan:
1. Reset, then an ideal 800x525 stream with negative syncs → locked=1 on the clock after the 3rd v leading edge; h_meas=800, v_meas=525, err_count=0.
2. Locked, observe one line → disp_ena rises 145 clocks after the h leading edge cycle with column=0; the first active line after the v edge has row=0, 35 lines after the edge; column=639 on the last active clock.
3. Locked, suppress one h pulse → h_meas=1600, locked and disp_ena 0 on the next clock, err_count=1. Relock after 3 further v edges.
4. Locked, both syncs held inactive → SEARCH after 1600 clocks, locked=0, err_count=1, h_meas stays 800.
5. Stream with 526-line frames or a 99-clock h pulse → locked never asserts over 10 frames; v_meas=526 in the first case.
6. Reset asserted for 1 clock while locked → all outputs 0 next clock; relock sequence as in scenario 1.
